// File: rtl/firstband_predictor.sv
// -----------------------------------------------------------------------------
// firstband_predictor
//   Lossless spatial predictor for the first band of each LCPLC block (slice).
//   Accepts raw samples in raster order, with end-of-row and end-of-block
//   markers. For every sample it emits one prediction built from that
//   sample's left (L) and upper (U) neighbours:
//     first row, first column  : 0
//     first row, other columns : L
//     other rows, first column : U
//     otherwise                : floor((L + U) / 2), sum one bit wider
//   Row length is implied by x_last_row. Rows longer than the buffer make the
//   column counter wrap. The output is then meaningless, but the block never
//   locks up.
//
// Handshake (both streams): a beat transfers on a rising clock edge where
//   valid && ready. A producer holds valid and its data stable until the beat
//   transfers. Ready may depend on the other side's state. There is a single
//   output register, so x_ready = !xtilde_valid || xtilde_ready, held low
//   during reset.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   x_valid/x_ready/x_data/x_last_row/x_last_slice   sample input stream
//   xtilde_valid/xtilde_ready/xtilde_data/xtilde_last prediction output stream
// -----------------------------------------------------------------------------
module firstband_predictor #(
    parameter int DATA_WIDTH          = 16,
    parameter int BLOCK_WIDTH_LOG_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DATA_WIDTH-1:0] x_data,
    input  logic                  x_last_row,
    input  logic                  x_last_slice,
    output logic                  xtilde_valid,
    input  logic                  xtilde_ready,
    output logic [DATA_WIDTH-1:0] xtilde_data,
    output logic                  xtilde_last
);

    localparam int DEPTH = 1 << BLOCK_WIDTH_LOG_MAX;
    localparam logic [BLOCK_WIDTH_LOG_MAX-1:0] COL_ZERO = '0;
    localparam logic [BLOCK_WIDTH_LOG_MAX-1:0] COL_ONE  = {{(BLOCK_WIDTH_LOG_MAX-1){1'b0}}, 1'b1};

    // Position state
    logic [BLOCK_WIDTH_LOG_MAX-1:0] col_q, col_d;
    logic                           first_row_q, first_row_d;
    logic [DATA_WIDTH-1:0]          left_q, left_d;

    // Output register
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;

    // The row buffer holds the previous row, indexed by column. It is
    // never read before it is written within a block, so it has no reset.
    logic [DATA_WIDTH-1:0] row_buf_q [DEPTH];

    logic                  accept;
    logic                  pop;
    logic [DATA_WIDTH-1:0] upper;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] pred;

    assign x_ready      = rst && (!valid_q || xtilde_ready);
    assign accept       = x_valid && x_ready;
    assign pop          = valid_q && xtilde_ready;
    assign xtilde_valid = valid_q;
    assign xtilde_data  = data_q;
    assign xtilde_last  = last_q;

    always_comb begin
        upper = row_buf_q[col_q];
        // The extra sum bit keeps 65535 + 65535 from overflowing before the halving.
        sum   = {1'b0, left_q} + {1'b0, upper};
        if (first_row_q && (col_q == COL_ZERO)) begin
            pred = '0;
        end else if (first_row_q) begin
            pred = left_q;
        end else if (col_q == COL_ZERO) begin
            pred = upper;
        end else begin
            pred = sum[DATA_WIDTH:1];
        end
    end

    always_comb begin
        col_d       = col_q;
        first_row_d = first_row_q;
        left_d      = left_q;
        valid_d     = valid_q;
        data_d      = data_q;
        last_d      = last_q;

        if (pop) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            valid_d = 1'b1;
            data_d  = pred;
            last_d  = x_last_slice;
            left_d  = x_data;
            // The end of a block also ends its row. The next sample starts
            // a new block in the first row.
            if (x_last_slice) begin
                col_d       = COL_ZERO;
                first_row_d = 1'b1;
            end else if (x_last_row) begin
                col_d       = COL_ZERO;
                first_row_d = 1'b0;
            end else begin
                col_d = col_q + COL_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            first_row_q <= 1'b1;
            left_q      <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            first_row_q <= first_row_d;
            left_q      <= left_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            last_q      <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            row_buf_q[col_q] <= x_data;
        end
    end

endmodule

// File: tb/tb_firstband_predictor.sv
module tb_firstband_predictor;

    logic        clk;
    logic        rst;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] x_data;
    logic        x_last_row;
    logic        x_last_slice;
    logic        xtilde_valid;
    logic        xtilde_ready;
    logic [15:0] xtilde_data;
    logic        xtilde_last;

    int total = 0;
    int bad   = 0;

    // Stimulus entries are {last_slice, last_row, data}. Expected and
    // observed entries are {last, prediction}.
    logic [17:0] stim_q[$];
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];

    // Reference model state: samples of the current row so far, and the
    // complete previous row of the current block.
    int cur_row[$];
    int prev_row[$];

    firstband_predictor #(
        .DATA_WIDTH(16),
        .BLOCK_WIDTH_LOG_MAX(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_data       (x_data),
        .x_last_row   (x_last_row),
        .x_last_slice (x_last_slice),
        .xtilde_valid (xtilde_valid),
        .xtilde_ready (xtilde_ready),
        .xtilde_data  (xtilde_data),
        .xtilde_last  (xtilde_last)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_clear();
        cur_row.delete();
        prev_row.delete();
        exp_q.delete();
    endfunction

    function automatic void model_push(input logic [17:0] s);
        int col;
        int p;
        col = cur_row.size();
        if (prev_row.size() == 0) begin
            p = (col == 0) ? 0 : cur_row[col-1];
        end else if (col == 0) begin
            p = prev_row[0];
        end else begin
            p = (cur_row[col-1] + prev_row[col]) / 2;
        end
        exp_q.push_back({s[17], p[15:0]});
        cur_row.push_back(int'(s[15:0]));
        if (s[17]) begin
            cur_row.delete();
            prev_row.delete();
        end else if (s[16]) begin
            prev_row = cur_row;
            cur_row.delete();
        end
    endfunction

    // mode 0: ramp, mode 1: random, mode 2: constant value cval
    task automatic add_block(input int w, input int h, input int mode, input int cval);
        logic [15:0] d;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (mode == 0)      d = 16'((r * w + c) * 97);
                else if (mode == 1) d = 16'($urandom);
                else                d = 16'(cval);
                stim_q.push_back({(r == h-1) && (c == w-1), c == w-1, d});
            end
        end
    endtask

    // ---------------- driver + scoreboard ----------------
    task automatic run_stream(input int v_pct, input int r_pct);
        int budget;
        logic [17:0] s;
        logic [16:0] e;
        budget = 0;
        got_q.delete();
        while ((stim_q.size() > 0 || exp_q.size() > 0) && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (stim_q.size() > 0 && $urandom_range(99) < v_pct) begin
                x_valid = 1'b1;
                {x_last_slice, x_last_row, x_data} = stim_q[0];
            end else begin
                x_valid      = 1'b0;
                x_data       = 16'($urandom);
                x_last_row   = 1'b0;
                x_last_slice = 1'b0;
            end
            xtilde_ready = ($urandom_range(99) < r_pct);
            #1;
            if (xtilde_valid && xtilde_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra: got {last,data}=%h, required none", {xtilde_last, xtilde_data});
                end else begin
                    e = exp_q.pop_front();
                    got_q.push_back({xtilde_last, xtilde_data});
                    if ({xtilde_last, xtilde_data} !== e) begin
                        bad++;
                        $display("FAIL stream_data: got {last,data}=%h, required %h", {xtilde_last, xtilde_data}, e);
                    end
                end
            end
            if (x_valid && x_ready) begin
                s = stim_q.pop_front();
                model_push(s);
            end
        end
        x_valid = 1'b0;
        total++;
        if (stim_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stream_timeout: got pending in=%0d out=%0d, required 0 0", stim_q.size(), exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst          = 1'b0;
        x_valid      = 1'b0;
        x_data       = '0;
        x_last_row   = 1'b0;
        x_last_slice = 1'b0;
        xtilde_ready = 1'b1;
        repeat (3) @(negedge clk);
        total += 4;
        if (xtilde_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", xtilde_valid); end
        if (xtilde_data !== 16'd0) begin bad++; $display("FAIL reset_data: got %0d, required 0", xtilde_data); end
        if (xtilde_last !== 1'b0)  begin bad++; $display("FAIL reset_last: got %b, required 0", xtilde_last); end
        if (x_ready !== 1'b0)      begin bad++; $display("FAIL reset_ready: got %b, required 0", x_ready); end
        rst = 1'b1;
        @(negedge clk);
        model_clear();
    endtask

    task automatic test_example_2x2();
        logic [16:0] want [4];
        want[0] = {1'b0, 16'd0};
        want[1] = {1'b0, 16'd10};
        want[2] = {1'b0, 16'd10};
        want[3] = {1'b1, 16'd25};
        stim_q.push_back({1'b0, 1'b0, 16'd10});
        stim_q.push_back({1'b0, 1'b1, 16'd20});
        stim_q.push_back({1'b0, 1'b0, 16'd30});
        stim_q.push_back({1'b1, 1'b1, 16'd40});
        run_stream(100, 100);
        total++;
        if (got_q.size() != 4) begin
            bad++;
            $display("FAIL example_count: got %0d, required 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_q[i] !== want[i]) begin
                    bad++;
                    $display("FAIL example_%0d: got %h, required %h", i, got_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_rounding();
        // L=3, U=4 on the last sample
        stim_q.push_back({1'b0, 1'b0, 16'd0});
        stim_q.push_back({1'b0, 1'b1, 16'd4});
        stim_q.push_back({1'b0, 1'b0, 16'd3});
        stim_q.push_back({1'b1, 1'b1, 16'd9});
        run_stream(100, 100);
        total++;
        if (got_q.size() != 4 || got_q[3] !== {1'b1, 16'd3}) begin
            bad++;
            $display("FAIL round_floor: got %h, required %h", (got_q.size() == 4) ? got_q[3] : 17'h0, {1'b1, 16'd3});
        end
        add_block(2, 2, 2, 65535);
        run_stream(100, 100);
        total++;
        if (got_q.size() != 4 || got_q[3] !== {1'b1, 16'hFFFF}) begin
            bad++;
            $display("FAIL round_max: got %h, required %h", (got_q.size() == 4) ? got_q[3] : 17'h0, {1'b1, 16'hFFFF});
        end
    endtask

    task automatic test_back_to_back();
        add_block(16, 16, 0, 0);
        add_block(3, 4, 1, 0);
        add_block(1, 5, 1, 0);  // single-column block
        run_stream(100, 100);
        total++;
        if (got_q.size() != 256 + 12 + 5 || got_q[256] !== 17'd0) begin
            bad++;
            $display("FAIL b2b_first: got %h, required 0", (got_q.size() > 256) ? got_q[256] : 17'h1FFFF);
        end
        add_block(5, 3, 1, 0);
        add_block(4, 4, 0, 0);
        run_stream(100, 100);
    endtask

    task automatic test_backpressure();
        logic [16:0] held;
        add_block(4, 4, 1, 0);
        @(negedge clk);
        x_valid = 1'b1;
        {x_last_slice, x_last_row, x_data} = stim_q[0];
        xtilde_ready = 1'b0;
        #1;
        total++;
        if (x_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_empty: got %b, required 1", x_ready);
        end
        if (x_ready) model_push(stim_q.pop_front());
        held = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            x_valid = 1'b1;
            {x_last_slice, x_last_row, x_data} = stim_q[0];
            xtilde_ready = 1'b0;
            #1;
            total += 2;
            if (x_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_ready_%0d: got %b, required 0", i, x_ready);
            end
            if ({xtilde_valid, xtilde_last, xtilde_data} !== {1'b1, held}) begin
                bad++;
                $display("FAIL bp_hold_%0d: got %h, required %h", i, {xtilde_valid, xtilde_last, xtilde_data}, {1'b1, held});
            end
        end
        run_stream(100, 100);
        total++;
        if (got_q.size() != 16) begin
            bad++;
            $display("FAIL bp_count: got %0d, required 16", got_q.size());
        end
    endtask

    task automatic test_stalls();
        logic [17:0] saved[$];
        logic [16:0] ref_seq[$];
        add_block(6, 5, 1, 0);
        add_block(3, 3, 0, 0);
        saved = stim_q;
        run_stream(100, 100);
        ref_seq = got_q;
        for (int k = 0; k < 3; k++) begin
            stim_q = saved;
            run_stream(30 + 25 * k, 40 + 20 * k);
            total++;
            if (got_q != ref_seq) begin
                bad++;
                $display("FAIL stall_seq_%0d: got %0d outputs differing, required identical %0d", k, got_q.size(), ref_seq.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        add_block(4, 4, 2, 1000);
        // Feed 6 samples: two into the second row, output register full.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            x_valid = 1'b1;
            {x_last_slice, x_last_row, x_data} = stim_q.pop_front();
            xtilde_ready = 1'b1;
        end
        @(negedge clk);
        x_valid = 1'b0;
        xtilde_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total += 4;
        if (xtilde_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b, required 0", xtilde_valid); end
        if (xtilde_data !== 16'd0) begin bad++; $display("FAIL midrst_data: got %0d, required 0", xtilde_data); end
        if (xtilde_last !== 1'b0)  begin bad++; $display("FAIL midrst_last: got %b, required 0", xtilde_last); end
        if (x_ready !== 1'b0)      begin bad++; $display("FAIL midrst_ready: got %b, required 0", x_ready); end
        stim_q.delete();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        add_block(3, 2, 2, 500);
        run_stream(100, 100);
        total++;
        if (got_q.size() != 6 || got_q[0] !== 17'd0 || got_q[1] !== {1'b0, 16'd500}) begin
            bad++;
            $display("FAIL midrst_first: got %h, required 0 then %h", (got_q.size() > 1) ? {got_q[0], got_q[1]} : 34'h0, {1'b0, 16'd500});
        end
    endtask

    initial begin
        test_reset();
        test_example_2x2();
        test_rounding();
        test_back_to_back();
        test_backpressure();
        test_stalls();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
